gal_olmc_bank: RTL

//   Parametrised bank of GAL22V10-style output logic macrocells (OLMCs) for the device models.

---
 rtl/gal_olmc_bank.sv | 88 ++++++++
 1 files changed

// File: rtl/gal_olmc_bank.sv
// gal_olmc_bank: bank of 22V10-style output logic macrocells.
// Serial shadow config chain with atomic commit to active config.
module gal_olmc_bank #(
  parameter int N_CELLS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CELLS-1:0] sum,
  input  logic [N_CELLS-1:0] oe_term,
  input  logic               sp,
  input  logic [N_CELLS-1:0] pin_in,
  input  logic               cfg_en,
  input  logic               cfg_di,
  input  logic               cfg_commit,
  output logic               cfg_do,
  output logic               cfg_valid,
  output logic [N_CELLS-1:0] pin_out,
  output logic [N_CELLS-1:0] pin_oe,
  output logic [N_CELLS-1:0] fb
);

  localparam int NB = 2 * N_CELLS;

  logic [N_CELLS-1:0] q_q, q_d;
  logic [NB-1:0]      sh_q, sh_d;
  logic [NB-1:0]      cfg_q, cfg_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic [N_CELLS-1:0] s0, s1;

  // Next state: rst over everything, preset over sum; chain is independent of q.
  always_comb begin
    q_d         = sp ? '1 : sum;
    sh_d        = sh_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    if (cfg_en) begin
      sh_d = {sh_q[NB-2:0], cfg_di};
    end
    if (cfg_commit) begin
      cfg_d       = sh_q;
      cfg_valid_d = 1'b1;
    end
    if (rst) begin
      q_d         = '0;
      sh_d        = '0;
      cfg_d       = '0;
      cfg_valid_d = 1'b0;
    end
  end

  // State registers, reset folded into the next-state logic.
  always_ff @(posedge clk) begin
    q_q         <= q_d;
    sh_q        <= sh_d;
    cfg_q       <= cfg_d;
    cfg_valid_q <= cfg_valid_d;
  end

  // Unpack interleaved active config into per-cell S0/S1.
  always_comb begin
    s0 = '0;
    s1 = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      s0[i] = cfg_q[2*i];
      s1[i] = cfg_q[2*i+1];
    end
  end

  // Output muxes: S1 picks comb vs registered, S0 picks polarity.
  always_comb begin
    pin_out = '0;
    fb      = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (s1[i]) begin
        pin_out[i] = s0[i] ? sum[i] : ~sum[i];
        fb[i]      = pin_in[i];
      end else begin
        pin_out[i] = s0[i] ? q_q[i] : ~q_q[i];
        fb[i]      = ~q_q[i];
      end
    end
  end

  assign pin_oe    = oe_term;
  assign cfg_do    = sh_q[NB-1];
  assign cfg_valid = cfg_valid_q;

endmodule
